render_scheduler: RTL

Per-frame controller that sequences the position-update engine, the sprite/background draw engine and the game-over overlay engine, and grants each one exclusive use of the frame-buffer write port.
- Sits between system_toplevel's keyboard/VGA timing logic and the engines.
- Drives eng_sel for the top-level frame-buffer write mux, plus the run_game_over level.
- A watchdog recovers the schedule if an engine never reports done.

---
 rtl/render_scheduler.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/render_scheduler.sv
// Per-frame scheduler: runs the position, draw and game-over engines in turn and
// hands the frame-buffer write port to whichever engine currently owns the frame.
module render_scheduler #(
    parameter int TIMEOUT = 500000,
    parameter int TO_W    = 20
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic        start_key,
    input  logic        game_over,
    input  logic        pos_done,
    input  logic        draw_done,
    input  logic        g_o_done,
    output logic        pos_start,
    output logic        draw_start,
    output logic        run_game_over,
    output logic [2:0]  eng_sel,
    output logic        fb_we_en,
    output logic [2:0]  state,
    output logic [15:0] frame_cnt,
    output logic [7:0]  overrun_cnt,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_TITLE = 3'd0,
        S_WAIT  = 3'd1,
        S_POS   = 3'd2,
        S_DRAW  = 3'd3,
        S_GO    = 3'd4,
        S_HOLD  = 3'd5
    } state_e;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              start_key_q, start_key_d;
    logic              pos_start_q, pos_start_d;
    logic              draw_start_q, draw_start_d;
    logic              run_game_over_q, run_game_over_d;
    logic [2:0]        eng_sel_q, eng_sel_d;
    logic              fb_we_en_q, fb_we_en_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [7:0]        overrun_cnt_q, overrun_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic [TO_W-1:0]   wdog_q, wdog_d;

    logic start_rise_s;
    logic busy_s;
    logic expired_s;
    logic entering_s;

    // Next-state, counters, watchdog and the registered per-state outputs
    always_comb begin
        state_d         = state_q;
        start_key_d     = start_key;
        frame_cnt_d     = frame_cnt_q;
        overrun_cnt_d   = overrun_cnt_q;
        timeout_err_d   = timeout_err_q;
        wdog_d          = wdog_q;
        pos_start_d     = 1'b0;
        draw_start_d    = 1'b0;
        run_game_over_d = 1'b0;
        eng_sel_d       = 3'd0;
        fb_we_en_d      = 1'b0;

        start_rise_s = start_key & ~start_key_q;
        busy_s       = (state_q == S_POS) || (state_q == S_DRAW) || (state_q == S_GO);
        expired_s    = busy_s && (wdog_q == WD_LAST);

        if (frame_start && ((state_q == S_POS) || (state_q == S_DRAW)) && (overrun_cnt_q != 8'hFF)) begin
            overrun_cnt_d = overrun_cnt_q + 8'd1;
        end else begin
            overrun_cnt_d = overrun_cnt_q;
        end

        // A done pulse on the expiry cycle takes priority over the watchdog
        case (state_q)
            S_TITLE: begin
                if (start_rise_s) state_d = S_WAIT;
                else              state_d = S_TITLE;
            end
            S_WAIT: begin
                if (frame_start) state_d = S_POS;
                else             state_d = S_WAIT;
            end
            S_POS: begin
                if (pos_done) begin
                    state_d = game_over ? S_GO : S_DRAW;
                end else if (expired_s) begin
                    state_d       = S_WAIT;
                    timeout_err_d = 1'b1;
                end else begin
                    state_d = S_POS;
                end
            end
            S_DRAW: begin
                if (draw_done) begin
                    state_d     = S_WAIT;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else if (expired_s) begin
                    state_d       = S_WAIT;
                    timeout_err_d = 1'b1;
                end else begin
                    state_d = S_DRAW;
                end
            end
            S_GO: begin
                if (g_o_done) begin
                    state_d = S_HOLD;
                end else if (expired_s) begin
                    state_d       = S_HOLD;
                    timeout_err_d = 1'b1;
                end else begin
                    state_d = S_GO;
                end
            end
            S_HOLD: begin
                if (start_rise_s) begin
                    state_d     = S_TITLE;
                    frame_cnt_d = 16'd0;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: state_d = S_TITLE;
        endcase

        entering_s = (state_d != state_q);

        if (entering_s) begin
            wdog_d = '0;
        end else if (busy_s) begin
            wdog_d = wdog_q + TO_W'(1);
        end else begin
            wdog_d = '0;
        end

        case (state_d)
            S_POS: begin
                eng_sel_d   = 3'd1;
                pos_start_d = entering_s;
            end
            S_DRAW: begin
                eng_sel_d    = 3'd2;
                fb_we_en_d   = 1'b1;
                draw_start_d = entering_s;
            end
            S_GO: begin
                eng_sel_d       = 3'd3;
                fb_we_en_d      = 1'b1;
                run_game_over_d = 1'b1;
            end
            default: begin
                eng_sel_d = 3'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q         <= S_TITLE;
            start_key_q     <= 1'b0;
            pos_start_q     <= 1'b0;
            draw_start_q    <= 1'b0;
            run_game_over_q <= 1'b0;
            eng_sel_q       <= 3'd0;
            fb_we_en_q      <= 1'b0;
            frame_cnt_q     <= 16'd0;
            overrun_cnt_q   <= 8'd0;
            timeout_err_q   <= 1'b0;
            wdog_q          <= '0;
        end else begin
            state_q         <= state_d;
            start_key_q     <= start_key_d;
            pos_start_q     <= pos_start_d;
            draw_start_q    <= draw_start_d;
            run_game_over_q <= run_game_over_d;
            eng_sel_q       <= eng_sel_d;
            fb_we_en_q      <= fb_we_en_d;
            frame_cnt_q     <= frame_cnt_d;
            overrun_cnt_q   <= overrun_cnt_d;
            timeout_err_q   <= timeout_err_d;
            wdog_q          <= wdog_d;
        end
    end

    assign state         = state_q;
    assign pos_start     = pos_start_q;
    assign draw_start    = draw_start_q;
    assign run_game_over = run_game_over_q;
    assign eng_sel       = eng_sel_q;
    assign fb_we_en      = fb_we_en_q;
    assign frame_cnt     = frame_cnt_q;
    assign overrun_cnt   = overrun_cnt_q;
    assign timeout_err   = timeout_err_q;

endmodule
